// File: rtl/td4_run_ctrl.sv
// ============================================================================
// Module      : td4_run_ctrl
// Description : Run-control sequencer for the TD4 core. Issues a single-cycle
//               cpu_en on CLK in place of a divided slow clock. Modes are
//               halted, free-run at DIV cycles per instruction, and debounced
//               single-step. Optional PC breakpoint when the macro
//               TD4_BREAKPOINT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module td4_run_ctrl #(
  parameter int unsigned DIV        = 50000000,
  parameter int unsigned DIV_W      = 26,
  parameter int unsigned DEB_CYCLES = 1000000,
  parameter int unsigned DEB_W      = 20
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       run_req,
  input  logic       step_btn,
  input  logic [3:0] pc,
  input  logic       bp_en,
  input  logic [3:0] bp_addr,
  output logic       cpu_en,
  output logic [1:0] state,
  output logic       halted,
  output logic [7:0] cycle_cnt
);

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_BRK  = 2'b11
  } state_e;

  localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             acc_q, acc_d;
  logic             step_ev_q, step_ev_d;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic             cpu_en_q, cpu_en_d;
  logic [7:0]       cycle_cnt_q, cycle_cnt_d;

`ifdef TD4_BREAKPOINT_EN
  logic             skip_q, skip_d;
  logic             bp_hit;
  // Breakpoint matches only while armed and not stepping off the same address.
  assign bp_hit = bp_en && !skip_q && (pc == bp_addr);
`else
  logic             unused_bp;
  assign unused_bp = ^{bp_en, bp_addr, pc};
`endif

  // Synchronize the key, debounce it, and pulse once on an accepted press.
  always_comb begin
    sync1_d   = step_btn;
    sync2_d   = sync1_q;
    deb_cnt_d = '0;
    acc_d     = acc_q;
    step_ev_d = 1'b0;
    if (sync2_q != acc_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        acc_d     = sync2_q;
        step_ev_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  // Mode sequencer: decides next state and whether an instruction executes.
  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    cpu_en_d    = 1'b0;
    cycle_cnt_d = cycle_cnt_q;
`ifdef TD4_BREAKPOINT_EN
    skip_d      = skip_q;
`endif
    case (state_q)
      ST_HALT: begin
        if (run_req) begin
          state_d = ST_RUN;
          presc_d = '0;
        end else if (step_ev_q) begin
          state_d  = ST_STEP;
          cpu_en_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (!run_req) begin
          state_d = ST_HALT;
          presc_d = '0;
        end else if (presc_q == PRESC_LAST) begin
          presc_d = '0;
`ifdef TD4_BREAKPOINT_EN
          if (bp_hit) begin
            state_d = ST_BRK;
          end else begin
            cpu_en_d = 1'b1;
          end
`else
          cpu_en_d = 1'b1;
`endif
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      ST_STEP: begin
        state_d = ST_HALT;
      end
`ifdef TD4_BREAKPOINT_EN
      ST_BRK: begin
        if (!run_req) begin
          state_d = ST_HALT;
        end else if (step_ev_q) begin
          state_d  = ST_STEP;
          cpu_en_d = 1'b1;
          skip_d   = 1'b1;
        end
      end
`endif
      default: begin
        state_d = ST_HALT;
      end
    endcase
    if (cpu_en_d) begin
      cycle_cnt_d = cycle_cnt_q + 1'b1;
    end
`ifdef TD4_BREAKPOINT_EN
    // Any executed instruction other than the step off a breakpoint re-arms it.
    if (cpu_en_d && (state_q != ST_BRK)) begin
      skip_d = 1'b0;
    end
`endif
  end

  // Register all state; reset overrides every other input.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      deb_cnt_q   <= '0;
      acc_q       <= 1'b0;
      step_ev_q   <= 1'b0;
      state_q     <= ST_HALT;
      presc_q     <= '0;
      cpu_en_q    <= 1'b0;
      cycle_cnt_q <= '0;
`ifdef TD4_BREAKPOINT_EN
      skip_q      <= 1'b0;
`endif
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_cnt_q   <= deb_cnt_d;
      acc_q       <= acc_d;
      step_ev_q   <= step_ev_d;
      state_q     <= state_d;
      presc_q     <= presc_d;
      cpu_en_q    <= cpu_en_d;
      cycle_cnt_q <= cycle_cnt_d;
`ifdef TD4_BREAKPOINT_EN
      skip_q      <= skip_d;
`endif
    end
  end

  assign cpu_en    = cpu_en_q;
  assign state     = state_q;
  assign halted    = (state_q != ST_RUN);
  assign cycle_cnt = cycle_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_td4_run_ctrl.sv
// ============================================================================
// Module      : tb_td4_run_ctrl
// Description : Directed self-checking bench for td4_run_ctrl with DIV=4 and
//               DEB_CYCLES=3. Breakpoint steps are built when
//               TD4_BREAKPOINT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_td4_run_ctrl;

  logic       CLK;
  logic       RST;
  logic       run_req;
  logic       step_btn;
  logic [3:0] pc;
  logic       bp_en;
  logic [3:0] bp_addr;
  logic       cpu_en;
  logic [1:0] state;
  logic       halted;
  logic [7:0] cycle_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  int pulses   = 0;
  bit pc_follow = 1'b0;

  td4_run_ctrl #(
    .DIV        (4),
    .DIV_W      (4),
    .DEB_CYCLES (3),
    .DEB_W      (4)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .run_req   (run_req),
    .step_btn  (step_btn),
    .pc        (pc),
    .bp_en     (bp_en),
    .bp_addr   (bp_addr),
    .cpu_en    (cpu_en),
    .state     (state),
    .halted    (halted),
    .cycle_cnt (cycle_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one clock, sample 1 ns later, count pulses and advance the PC.
  task automatic tick();
    @(posedge CLK);
    #1;
    if (cpu_en === 1'b1) begin
      pulses++;
      if (pc_follow) pc = pc + 4'd1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    RST = 1'b1; run_req = 1'b1; step_btn = 1'b1;
    pc = 4'd0; bp_en = 1'b0; bp_addr = 4'd0;

    // Reset holds off everything
    tick();
    chk("rst1_state", state, 0);  chk("rst1_cpu_en", cpu_en, 0);
    chk("rst1_halted", halted, 1); chk("rst1_cnt", cycle_cnt, 0);
    tick();
    chk("rst2_state", state, 0);  chk("rst2_cpu_en", cpu_en, 0);
    chk("rst2_halted", halted, 1); chk("rst2_cnt", cycle_cnt, 0);
    RST = 1'b0; step_btn = 1'b0;
    chk("rel_state", state, 0);   chk("rel_cpu_en", cpu_en, 0);

    // Free run: pulse every 4 cycles, first 4 cycles after entry
    tick();
    chk("run_entry_state", state, 1); chk("run_entry_halted", halted, 0);
    pulses = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      chk("run_pulse", cpu_en, ((i % 4) == 0) ? 1 : 0);
    end
    chk("run_pulses", pulses, 10);
    chk("run_cnt", cycle_cnt, 10);
    run_req = 1'b0;
    tick();
    chk("stop_state", state, 0); chk("stop_halted", halted, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("stop_no_pulse", cpu_en, 0);
    end
    chk("stop_cnt", cycle_cnt, 10);

    // Two-cycle glitch must be rejected
    pulses = 0;
    step_btn = 1'b1;
    tick(); tick();
    step_btn = 1'b0;
    repeat (10) tick();
    chk("glitch_pulses", pulses, 0);
    chk("glitch_state", state, 0);

    // Clean press: accepted after sync (2) + debounce (3), STEP on the next edge
    step_btn = 1'b1;
    repeat (5) tick();
    chk("step_pre_state", state, 0); chk("step_pre_cpu_en", cpu_en, 0);
    tick();
    chk("step_state", state, 2); chk("step_cpu_en", cpu_en, 1);
    chk("step_cnt", cycle_cnt, 11);
    tick();
    chk("step_after_state", state, 0); chk("step_after_cpu_en", cpu_en, 0);
    tick();
    step_btn = 1'b0;
    pulses = 0;
    repeat (12) tick();
    chk("release_pulses", pulses, 0);
    chk("release_cnt", cycle_cnt, 11);

    // Reset mid-RUN with prescaler at 2
    run_req = 1'b1;
    tick();
    chk("r6_entry", state, 1);
    tick(); tick();
    RST = 1'b1;
    tick();
    chk("r6_cpu_en", cpu_en, 0); chk("r6_state", state, 0);
    chk("r6_cnt", cycle_cnt, 0);
    RST = 1'b0;
    tick();
    chk("r6_resume", state, 1);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("r6_no_pulse", cpu_en, 0);
    end
    tick();
    chk("r6_first_pulse", cpu_en, 1);
    chk("r6_first_cnt", cycle_cnt, 1);

    // Counter wrap: 256 pulses since reset brings cycle_cnt back to 0
    guard = 0;
    while (pulses < 256 && guard < 1200) begin
      tick();
      guard++;
      if (cpu_en === 1'b1 && pulses == 255) chk("wrap_cnt_255", cycle_cnt, 255);
    end
    chk("wrap_pulses", pulses, 256);
    chk("wrap_cpu_en", cpu_en, 1);
    chk("wrap_cnt", cycle_cnt, 0);
    run_req = 1'b0;
    tick();
    chk("wrap_stop", state, 0);

`ifdef TD4_BREAKPOINT_EN
    // Breakpoint at 5: pc 0..4 executes, then BRK without a pulse
    RST = 1'b1;
    tick();
    RST = 1'b0;
    pc = 4'd0; bp_en = 1'b1; bp_addr = 4'd5; pc_follow = 1'b1;
    run_req = 1'b1;
    pulses = 0;
    tick();
    chk("bp_entry", state, 1);
    repeat (24) tick();
    chk("bp_pulses", pulses, 5); chk("bp_state", state, 3);
    chk("bp_pc", pc, 5); chk("bp_cnt", cycle_cnt, 5); chk("bp_cpu_en", cpu_en, 0);
    repeat (8) tick();
    chk("bp_hold_state", state, 3); chk("bp_hold_pulses", pulses, 5);
    step_btn = 1'b1;
    repeat (5) tick();
    tick();
    chk("bp_step_state", state, 2); chk("bp_step_cpu_en", cpu_en, 1);
    chk("bp_step_cnt", cycle_cnt, 6);
    tick();
    chk("bp_step_halt", state, 0);
    tick();
    chk("bp_step_run", state, 1);
    step_btn = 1'b0; run_req = 1'b0;
    tick();
    chk("bp_drop", state, 0);
    run_req = 1'b1;
    tick();
    chk("bp_rerun", state, 1);
    pulses = 0;
    repeat (20) tick();
    chk("bp_past_pulses", pulses, 5); chk("bp_past_state", state, 1);
    chk("bp_past_pc", pc, 11);
    run_req = 1'b0; pc_follow = 1'b0; bp_en = 1'b0;
    tick();
`else
    // Without the breakpoint feature a matching PC never stops the run
    RST = 1'b1;
    tick();
    RST = 1'b0;
    pc = 4'd0; bp_en = 1'b1; bp_addr = 4'd0;
    run_req = 1'b1;
    pulses = 0;
    tick();
    chk("nobp_entry", state, 1);
    repeat (12) tick();
    chk("nobp_pulses", pulses, 3);
    chk("nobp_state", state, 1);
    run_req = 1'b0;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
